wbs_port_arbiter: RTL and testbench
===================================

Name: wbs_port_arbiter

Overview:
- Shares the core's single memory-mapped slave port between two requesters: the Caravel management Wishbone slave (wbs_*) and a logic-analyzer-driven debug master (dbg_*).
- Sits inside rift2Wrap, between the wrapper pins and the core bus.
- Grants one transaction at a time, round-robin, and forwards it downstream.
- Returns the response to the granted requester, or an error response after a bus timeout.

Parameters:
- AW, 32: address width.
- DW, 32: data width; the select width is DW/8.
- TIMEOUT, 255: maximum number of BUSY cycles without m_ack_i before the transaction is aborted; legal range 1..65535.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  Wishbone write enable
- wbs_adr_i  in  AW  Wishbone address
- wbs_dat_i  in  DW  Wishbone write data
- wbs_sel_i  in  DW/8  Wishbone byte selects
- wbs_ack_o  out  1  Wishbone acknowledge, one-cycle pulse
- wbs_dat_o  out  DW  Wishbone read data, valid with wbs_ack_o
- dbg_req_i  in  1  debug request level, held until dbg_ack_o
- dbg_we_i, dbg_adr_i, dbg_dat_i, dbg_sel_i  in  1/AW/DW/DW/8  debug write enable, address, write data, byte selects
- dbg_ack_o  out  1  debug acknowledge, one-cycle pulse
- dbg_err_o  out  1  debug error, valid with dbg_ack_o
- dbg_rdata_o  out  DW  debug read data, valid with dbg_ack_o
- m_valid_o  out  1  downstream request
- m_we_o, m_adr_o, m_wdata_o, m_sel_o  out  1/AW/DW/DW/8  downstream command fields
- m_ack_i  in  1  downstream completion
- m_rdata_i  in  DW  downstream read data, valid with m_ack_i
- timeout_o  out  1  one-cycle pulse on each abort

Behaviour:
- Clocking and reset: clock is wb_clk_i; reset is wb_rst_i, synchronous and active-high.
- Reset values:
  - All outputs 0.
  - FSM = IDLE; timeout counter = 0.
  - rr_last = DBG, so the Wishbone requester wins the first tie.
- Request definitions: Wishbone pending = wbs_cyc_i & wbs_stb_i. Debug pending = dbg_req_i.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any request is pending, grant it; with both pending, grant the requester that is not rr_last.
  - Register the granted command fields into m_* and record the owner; go to BUSY.
  - m_valid_o is 1 from the next cycle.
- BUSY:
  - m_valid_o = 1; m_* fields are held stable.
  - Counter increments every cycle.
  - If m_ack_i: capture m_rdata_i, err = 0, go to RESP.
  - Else, if counter == TIMEOUT-1: err = 1, read data = all ones, pulse timeout_o, go to RESP.
  - m_ack_i in the same cycle as expiry: the ack wins, no timeout.
  - m_valid_o is deasserted on leaving BUSY.
- RESP:
  - Drive exactly one ack pulse to the owner: wbs_ack_o with wbs_dat_o, or dbg_ack_o with dbg_rdata_o and dbg_err_o.
  - A Wishbone owner on timeout gets an ack with 0xFFFFFFFF; Caravel has no err line.
  - Set rr_last = owner; clear the counter; go to IDLE.
- Write transactions: read-data outputs are still driven (don't-care to requesters); verification checks only err/ack.
- Wishbone abort: if wbs_cyc_i drops while owned in BUSY, the downstream transaction still completes. The RESP ack is suppressed if wbs_cyc_i & wbs_stb_i is 0 in RESP.
- Latency: with zero-wait downstream, request sampled at cycle 0 → m_valid_o and m_ack_i at cycle 1 → requester ack at cycle 2. Throughput is one transaction per 3 cycles.
- Output timing: outputs are registered; no combinational path from requester inputs to m_* or to the acks.
- Data outputs: wbs_dat_o and dbg_rdata_o hold their last value outside ack cycles; only ack qualifies them.
- Requester obligations: requesters drop the request in the cycle after ack or issue a new one. A request still pending in IDLE is treated as new.
- Reset mid-transaction: return to IDLE next cycle; the pending ack is discarded; m_valid_o = 0; rr_last = DBG.

Test Plan:
- Zero-wait single transaction: Wishbone read at 0x3000_0004 with m_ack_i in the first BUSY cycle and m_rdata_i = 0xA5A5_0001 → m_valid_o 1 cycle; wbs_ack_o exactly 1 pulse at cycle 2 with wbs_dat_o = 0xA5A5_0001; dbg_ack_o stays 0.
- Simultaneous and back-to-back requests: Wishbone write (0x10, 0x1234_5678, sel = 0xF) and debug read (0x20) asserted in the same cycle after reset → Wishbone granted first (m_adr_o = 0x10), debug second (m_adr_o = 0x20). With both held continuously, grants alternate W, D, W, D.
- Timeout: TIMEOUT = 4, debug read, m_ack_i held 0 → m_valid_o high exactly 4 cycles; timeout_o pulse; dbg_ack_o with dbg_err_o = 1 and dbg_rdata_o = 0xFFFFFFFF. Repeat with m_ack_i on the 4th cycle → err = 0, no timeout_o.
- Wishbone abort: drop wbs_cyc_i in BUSY, m_ack_i after 3 cycles → no wbs_ack_o; FSM returns to IDLE; a following debug request is served normally.
- Reset mid-operation: assert wb_rst_i during BUSY → next cycle all outputs 0, no ack. Then a simultaneous W/D request → Wishbone granted first.

Source files
------------

// File: rtl/wbs_port_arbiter_if.sv
// Bus bundle for the two-requester slave-port arbiter: Caravel Wishbone
// slave side, logic-analyzer debug side and the downstream core bus.
// The arbiter uses the slave modport; a driver of all requesters and the
// downstream responder uses the master modport.
interface wbs_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Caravel management Wishbone requester
    logic              wbs_cyc_i;
    logic              wbs_stb_i;
    logic              wbs_we_i;
    logic [AW-1:0]     wbs_adr_i;
    logic [DW-1:0]     wbs_dat_i;
    logic [DW/8-1:0]   wbs_sel_i;
    logic              wbs_ack_o;
    logic [DW-1:0]     wbs_dat_o;

    // Logic-analyzer debug requester
    logic              dbg_req_i;
    logic              dbg_we_i;
    logic [AW-1:0]     dbg_adr_i;
    logic [DW-1:0]     dbg_dat_i;
    logic [DW/8-1:0]   dbg_sel_i;
    logic              dbg_ack_o;
    logic              dbg_err_o;
    logic [DW-1:0]     dbg_rdata_o;

    // Downstream core bus
    logic              m_valid_o;
    logic              m_we_o;
    logic [AW-1:0]     m_adr_o;
    logic [DW-1:0]     m_wdata_o;
    logic [DW/8-1:0]   m_sel_o;
    logic              m_ack_i;
    logic [DW-1:0]     m_rdata_i;

    // Abort indication
    logic              timeout_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        output wbs_ack_o, wbs_dat_o,
        input  dbg_req_i, dbg_we_i, dbg_adr_i, dbg_dat_i, dbg_sel_i,
        output dbg_ack_o, dbg_err_o, dbg_rdata_o,
        output m_valid_o, m_we_o, m_adr_o, m_wdata_o, m_sel_o,
        input  m_ack_i, m_rdata_i,
        output timeout_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_adr_i, wbs_dat_i, wbs_sel_i,
        input  wbs_ack_o, wbs_dat_o,
        output dbg_req_i, dbg_we_i, dbg_adr_i, dbg_dat_i, dbg_sel_i,
        input  dbg_ack_o, dbg_err_o, dbg_rdata_o,
        input  m_valid_o, m_we_o, m_adr_o, m_wdata_o, m_sel_o,
        output m_ack_i, m_rdata_i,
        input  timeout_o
    );
endinterface

// File: rtl/wbs_port_arbiter.sv
// Round-robin arbiter sharing the core's single slave port between the
// Caravel Wishbone slave and the logic-analyzer debug master. One transaction
// is in flight at a time; a stalled downstream is aborted after TIMEOUT busy
// cycles and answered with all-ones data (plus err for the debug side).
// Every output is a flop, so requester inputs never reach m_* or the acks
// combinationally. The response is launched on the edge that leaves BUSY,
// which places the single ack pulse in the RESP cycle; a Wishbone owner that
// has already dropped cyc/stb by then receives no ack.
module wbs_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    wbs_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_WB, OWN_DBG} owner_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t          state;
    state_t          state_next;
    owner_t          owner;
    owner_t          rr_last;
    logic [15:0]     cnt;

    logic            wb_pend;
    logic            dbg_pend;
    logic            grant;
    logic            grant_dbg;
    logic            done_ack;
    logic            done_exp;
    logic [DW-1:0]   rsp_data;

    assign wb_pend  = bus.wbs_cyc_i & bus.wbs_stb_i;
    assign dbg_pend = bus.dbg_req_i;

    // Next-state logic and the per-cycle grant/completion decisions
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_dbg  = 1'b0;
        done_ack   = 1'b0;
        done_exp   = 1'b0;
        rsp_data   = bus.m_rdata_i;
        case (state)
            IDLE: begin
                if (wb_pend || dbg_pend) begin
                    grant      = 1'b1;
                    grant_dbg  = dbg_pend && (!wb_pend || rr_last == OWN_WB);
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (bus.m_ack_i) begin
                    done_ack   = 1'b1;
                    state_next = RESP;
                end else if (cnt == TIMEOUT_LAST) begin
                    done_exp   = 1'b1;
                    rsp_data   = '1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command capture, busy counter, response launch and round-robin pointer
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            owner           <= OWN_WB;
            rr_last         <= OWN_DBG;
            cnt             <= '0;
            bus.m_valid_o   <= 1'b0;
            bus.m_we_o      <= 1'b0;
            bus.m_adr_o     <= '0;
            bus.m_wdata_o   <= '0;
            bus.m_sel_o     <= '0;
            bus.wbs_ack_o   <= 1'b0;
            bus.wbs_dat_o   <= '0;
            bus.dbg_ack_o   <= 1'b0;
            bus.dbg_err_o   <= 1'b0;
            bus.dbg_rdata_o <= '0;
            bus.timeout_o   <= 1'b0;
        end else begin
            bus.wbs_ack_o <= 1'b0;
            bus.dbg_ack_o <= 1'b0;
            bus.timeout_o <= 1'b0;

            if (grant) begin
                bus.m_valid_o <= 1'b1;
                if (grant_dbg) begin
                    owner         <= OWN_DBG;
                    bus.m_we_o    <= bus.dbg_we_i;
                    bus.m_adr_o   <= bus.dbg_adr_i;
                    bus.m_wdata_o <= bus.dbg_dat_i;
                    bus.m_sel_o   <= bus.dbg_sel_i;
                end else begin
                    owner         <= OWN_WB;
                    bus.m_we_o    <= bus.wbs_we_i;
                    bus.m_adr_o   <= bus.wbs_adr_i;
                    bus.m_wdata_o <= bus.wbs_dat_i;
                    bus.m_sel_o   <= bus.wbs_sel_i;
                end
            end

            if (state == BUSY) begin
                cnt <= cnt + 16'd1;
            end

            if (done_ack || done_exp) begin
                bus.m_valid_o <= 1'b0;
                bus.timeout_o <= done_exp;
                if (owner == OWN_WB) begin
                    bus.wbs_ack_o <= wb_pend;
                    bus.wbs_dat_o <= rsp_data;
                end else begin
                    bus.dbg_ack_o   <= 1'b1;
                    bus.dbg_err_o   <= done_exp;
                    bus.dbg_rdata_o <= rsp_data;
                end
            end

            if (state == RESP) begin
                rr_last <= owner;
                cnt     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wbs_port_arbiter.sv
// Directed self-checking bench for wbs_port_arbiter (TIMEOUT = 4).
// Inputs change 1 time unit after each rising edge; outputs are checked at
// the same point, so each check sees the state produced by the last edge.
module tb_wbs_port_arbiter;

    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    int   checks   = 0;
    int   errors   = 0;

    wbs_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    wbs_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    // Free-running clock
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic w_req, input logic w_we, input logic [31:0] w_adr,
                                 input logic [31:0] w_dat, input logic d_req, input logic d_we,
                                 input logic [31:0] d_adr);
        bus.wbs_cyc_i = w_req;
        bus.wbs_stb_i = w_req;
        bus.wbs_we_i  = w_we;
        bus.wbs_adr_i = w_adr;
        bus.wbs_dat_i = w_dat;
        bus.wbs_sel_i = 4'hF;
        bus.dbg_req_i = d_req;
        bus.dbg_we_i  = d_we;
        bus.dbg_adr_i = d_adr;
        bus.dbg_dat_i = 32'hCAFE0000;
        bus.dbg_sel_i = 4'hF;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_m_valid"},   64'(bus.m_valid_o),   64'h0);
        checkOutput({tag, "_m_adr"},     64'(bus.m_adr_o),     64'h0);
        checkOutput({tag, "_wbs_ack"},   64'(bus.wbs_ack_o),   64'h0);
        checkOutput({tag, "_wbs_dat"},   64'(bus.wbs_dat_o),   64'h0);
        checkOutput({tag, "_dbg_ack"},   64'(bus.dbg_ack_o),   64'h0);
        checkOutput({tag, "_dbg_rdata"}, 64'(bus.dbg_rdata_o), 64'h0);
        checkOutput({tag, "_timeout"},   64'(bus.timeout_o),   64'h0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        bus.m_ack_i   = 1'b0;
        bus.m_rdata_i = 32'h0;

        // Reset state
        wb_rst_i = 1'b1;
        tick();
        tick();
        wb_rst_i = 1'b0;
        checkAllZero("reset");

        // Zero-wait Wishbone read
        applyStimulus(1'b1, 1'b0, 32'h3000_0004, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("zw_valid", 64'(bus.m_valid_o), 64'h1);
        checkOutput("zw_adr",   64'(bus.m_adr_o),   64'h3000_0004);
        checkOutput("zw_we",    64'(bus.m_we_o),    64'h0);
        bus.m_ack_i   = 1'b1;
        bus.m_rdata_i = 32'hA5A5_0001;
        tick();
        checkOutput("zw_ack",      64'(bus.wbs_ack_o), 64'h1);
        checkOutput("zw_dat",      64'(bus.wbs_dat_o), 64'hA5A5_0001);
        checkOutput("zw_dbg_ack",  64'(bus.dbg_ack_o), 64'h0);
        checkOutput("zw_valid_lo", 64'(bus.m_valid_o), 64'h0);
        bus.m_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("zw_ack_pulse", 64'(bus.wbs_ack_o), 64'h0);
        checkOutput("zw_dat_hold",  64'(bus.wbs_dat_o), 64'hA5A5_0001);

        // Simultaneous requests after reset, then continuous alternation
        wb_rst_i = 1'b1;
        tick();
        wb_rst_i = 1'b0;
        bus.m_ack_i   = 1'b1;
        bus.m_rdata_i = 32'hDEAD_0020;
        applyStimulus(1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b1, 1'b0, 32'h20);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("rr%0d_valid", i), 64'(bus.m_valid_o), 64'h1);
            checkOutput($sformatf("rr%0d_adr", i), 64'(bus.m_adr_o), (i % 2 == 0) ? 64'h10 : 64'h20);
            if (i == 0) begin
                checkOutput("rr0_we",    64'(bus.m_we_o),    64'h1);
                checkOutput("rr0_wdata", 64'(bus.m_wdata_o), 64'h1234_5678);
                checkOutput("rr0_sel",   64'(bus.m_sel_o),   64'hF);
            end
            tick();
            checkOutput($sformatf("rr%0d_wbs_ack", i), 64'(bus.wbs_ack_o), (i % 2 == 0) ? 64'h1 : 64'h0);
            checkOutput($sformatf("rr%0d_dbg_ack", i), 64'(bus.dbg_ack_o), (i % 2 == 0) ? 64'h0 : 64'h1);
            if (i == 1) begin
                checkOutput("rr1_rdata", 64'(bus.dbg_rdata_o), 64'hDEAD_0020);
                checkOutput("rr1_err",   64'(bus.dbg_err_o),   64'h0);
            end
            if (i == 3) begin
                applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
            end
            tick();
            checkOutput($sformatf("rr%0d_idle", i), 64'(bus.m_valid_o), 64'h0);
        end
        bus.m_ack_i = 1'b0;

        // Timeout on a debug read with no downstream ack
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h40);
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            checkOutput($sformatf("to_valid%0d", c), 64'(bus.m_valid_o), 64'h1);
            checkOutput($sformatf("to_early%0d", c), 64'(bus.timeout_o), 64'h0);
        end
        tick();
        checkOutput("to_valid_lo", 64'(bus.m_valid_o),   64'h0);
        checkOutput("to_pulse",    64'(bus.timeout_o),   64'h1);
        checkOutput("to_dbg_ack",  64'(bus.dbg_ack_o),   64'h1);
        checkOutput("to_err",      64'(bus.dbg_err_o),   64'h1);
        checkOutput("to_rdata",    64'(bus.dbg_rdata_o), 64'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("to_pulse_end", 64'(bus.timeout_o), 64'h0);

        // Ack on the last allowed busy cycle wins over expiry
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h44);
        for (int c = 1; c <= TIMEOUT; c++) begin
            tick();
            checkOutput($sformatf("late_valid%0d", c), 64'(bus.m_valid_o), 64'h1);
            if (c == TIMEOUT) begin
                bus.m_ack_i   = 1'b1;
                bus.m_rdata_i = 32'h0BAD_F00D;
            end
        end
        tick();
        checkOutput("late_ack",     64'(bus.dbg_ack_o),   64'h1);
        checkOutput("late_err",     64'(bus.dbg_err_o),   64'h0);
        checkOutput("late_rdata",   64'(bus.dbg_rdata_o), 64'h0BAD_F00D);
        checkOutput("late_timeout", 64'(bus.timeout_o),   64'h0);
        bus.m_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        // Wishbone abort: cyc drops while busy, downstream still completes
        applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("ab_valid1", 64'(bus.m_valid_o), 64'h1);
        checkOutput("ab_adr",    64'(bus.m_adr_o),   64'h50);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("ab_valid2", 64'(bus.m_valid_o), 64'h1);
        tick();
        checkOutput("ab_valid3", 64'(bus.m_valid_o), 64'h1);
        bus.m_ack_i   = 1'b1;
        bus.m_rdata_i = 32'h5555_AAAA;
        tick();
        checkOutput("ab_no_ack",   64'(bus.wbs_ack_o), 64'h0);
        checkOutput("ab_valid_lo", 64'(bus.m_valid_o), 64'h0);
        bus.m_ack_i = 1'b0;
        tick();
        checkOutput("ab_idle_ack", 64'(bus.wbs_ack_o), 64'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h60);
        tick();
        checkOutput("ab_dbg_valid", 64'(bus.m_valid_o), 64'h1);
        checkOutput("ab_dbg_adr",   64'(bus.m_adr_o),   64'h60);
        bus.m_ack_i   = 1'b1;
        bus.m_rdata_i = 32'h6060_6060;
        tick();
        checkOutput("ab_dbg_ack",   64'(bus.dbg_ack_o),   64'h1);
        checkOutput("ab_dbg_rdata", 64'(bus.dbg_rdata_o), 64'h6060_6060);
        bus.m_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        // Reset while busy; Wishbone owns rr_last beforehand so the tie after
        // reset only goes to Wishbone if the pointer was reset to debug
        bus.m_ack_i   = 1'b1;
        bus.m_rdata_i = 32'h1111_2222;
        applyStimulus(1'b1, 1'b0, 32'h70, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rs_pre_ack", 64'(bus.wbs_ack_o), 64'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80);
        tick();
        checkOutput("rs_busy_adr", 64'(bus.m_adr_o), 64'h80);
        wb_rst_i = 1'b1;
        tick();
        checkAllZero("rs_mid");
        wb_rst_i = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h90, 32'h0, 1'b1, 1'b0, 32'h80);
        tick();
        checkOutput("rs_tie_valid", 64'(bus.m_valid_o), 64'h1);
        checkOutput("rs_tie_adr",   64'(bus.m_adr_o),   64'h90);
        tick();
        checkOutput("rs_tie_wack", 64'(bus.wbs_ack_o), 64'h1);
        checkOutput("rs_tie_dack", 64'(bus.dbg_ack_o), 64'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        bus.m_ack_i = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
